// File: rtl/nor_op_pkg.sv
// rtl/nor_op_pkg.sv - opcode and FSM state encodings for the NOR op scheduler
package nor_op_pkg;

  typedef enum logic [1:0] {
    OP_NOT   = 2'b00,
    OP_OR    = 2'b01,
    OP_AND   = 2'b10,
    OP_IMPLY = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/nor_cell.sv
// rtl/nor_cell.sv - combinational WIDTH-bit bitwise NOR
module nor_cell #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = ~(x_i | y_i);

endmodule

// File: rtl/nor_op_scheduler.sv
// rtl/nor_op_scheduler.sv - two-requester round-robin scheduler evaluating ops on one shared NOR
module nor_op_scheduler
  import nor_op_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_i,
  input  logic [1:0]       op0_i,
  input  logic [1:0]       op1_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  output logic [1:0]       gnt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             id_o,
  output logic [WIDTH-1:0] result_o
);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, t1_q, t2_q, result_q;
  logic             id_q, last_q, busy_q, done_q;
  logic [1:0]       gnt_q;

  logic             win_d, last_step_d;
  logic [WIDTH-1:0] x_d, y_d, nor_y;

  nor_cell #(.WIDTH(WIDTH)) u_nor (
    .x_i (x_d),
    .y_i (y_d),
    .y_o (nor_y)
  );

  // last_q holds the requester served most recently; on a tie the other one wins
  assign win_d = req_i[1] & (~req_i[0] | ~last_q);

  always_comb begin
    x_d         = a_q;
    y_d         = a_q;
    last_step_d = 1'b0;
    case (state_q)
      S1: begin
        case (op_q)
          OP_NOT:  last_step_d = 1'b1;
          OP_OR:   y_d = b_q;
          default: ;
        endcase
      end
      S2: begin
        case (op_q)
          OP_OR: begin
            x_d         = t1_q;
            y_d         = t1_q;
            last_step_d = 1'b1;
          end
          OP_AND: begin
            x_d = b_q;
            y_d = b_q;
          end
          OP_IMPLY: begin
            x_d = t1_q;
            y_d = b_q;
          end
          default: ;
        endcase
      end
      S3: begin
        x_d         = (op_q == OP_AND) ? t1_q : t2_q;
        y_d         = t2_q;
        last_step_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_NOT;
      a_q      <= '0;
      b_q      <= '0;
      t1_q     <= '0;
      t2_q     <= '0;
      result_q <= '0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gnt_q    <= 2'b00;
    end else begin
      gnt_q  <= 2'b00;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            id_q    <= win_d;
            last_q  <= win_d;
            op_q    <= win_d ? op_e'(op1_i) : op_e'(op0_i);
            a_q     <= win_d ? a1_i : a0_i;
            b_q     <= win_d ? b1_i : b0_i;
            gnt_q   <= win_d ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            state_q <= S1;
          end
        end
        S1, S2, S3: begin
          if (state_q == S1)      t1_q <= nor_y;
          else if (state_q == S2) t2_q <= nor_y;
          if (last_step_d) begin
            result_q <= nor_y;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            state_q <= (state_q == S1) ? S2 : S3;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o    = gnt_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign id_o     = id_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_nor_op_scheduler.sv
// tb/tb_nor_op_scheduler.sv - directed self-checking bench for nor_op_scheduler
module tb_nor_op_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_i, op0_i, op1_i;
  logic [3:0] a0_i, b0_i, a1_i, b1_i;
  logic [1:0] gnt_o;
  logic       busy_o, done_o, id_o;
  logic [3:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;

  nor_op_scheduler #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .op0_i    (op0_i),
    .op1_i    (op1_i),
    .a0_i     (a0_i),
    .b0_i     (b0_i),
    .a1_i     (a1_i),
    .b1_i     (b1_i),
    .gnt_o    (gnt_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .id_o     (id_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " gnt"},  gnt_o,  2'b00);
    check_eq({tag, " busy"}, busy_o, 1'b0);
    check_eq({tag, " done"}, done_o, 1'b0);
  endtask

  // Called while the DUT is in IDLE; the next edge is the sampling edge.
  task automatic run_op(input string tag, input logic [1:0] req, input int n_steps,
                        input logic exp_id, input logic [3:0] exp_res,
                        input bit drop_req, input bit scramble);
    int cyc;
    req_i = req;
    tick();
    check_eq({tag, " gnt"}, gnt_o, exp_id ? 2'b10 : 2'b01);
    check_eq({tag, " busy"}, busy_o, 1'b1);
    if (drop_req) req_i = 2'b00;
    cyc = 1;
    while (!done_o && cyc < 10) begin
      if (scramble) begin
        a0_i = 4'($urandom);
        b0_i = 4'($urandom);
      end
      tick();
      cyc++;
      if (cyc == 2) check_eq({tag, " gnt pulse"}, gnt_o, 2'b00);
    end
    check_eq({tag, " latency"}, cyc, n_steps + 1);
    check_eq({tag, " done"}, done_o, 1'b1);
    check_eq({tag, " id"}, id_o, exp_id);
    check_eq({tag, " result"}, result_o, exp_res);
    check_eq({tag, " busy at done"}, busy_o, 1'b1);
    tick();
    check_eq({tag, " done pulse"}, done_o, 1'b0);
    check_eq({tag, " busy after"}, busy_o, 1'b0);
    check_eq({tag, " result held"}, result_o, exp_res);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_i = 2'b00;
    op0_i = 2'b00; op1_i = 2'b00;
    a0_i = 4'h0; b0_i = 4'h0; a1_i = 4'h0; b1_i = 4'h0;
    tick();
    tick();
    check_idle_outputs("reset");
    check_eq("reset id", id_o, 1'b0);
    check_eq("reset result", result_o, 4'b0000);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle_outputs("idle");
    end

    op0_i = 2'b10; a0_i = 4'b1100; b0_i = 4'b1010;
    run_op("and r0", 2'b01, 3, 1'b0, 4'b1000, 1'b1, 1'b0);

    op1_i = 2'b11; a1_i = 4'b1100; b1_i = 4'b1010;
    run_op("imply r1", 2'b10, 3, 1'b1, 4'b1011, 1'b1, 1'b0);

    op1_i = 2'b00; a1_i = 4'b0110;
    run_op("not r1", 2'b10, 1, 1'b1, 4'b1001, 1'b1, 1'b0);

    op0_i = 2'b01; a0_i = 4'b0101; b0_i = 4'b0011;
    op1_i = 2'b01; a1_i = 4'b1000; b1_i = 4'b0001;
    run_op("rr first", 2'b11, 2, 1'b0, 4'b0111, 1'b0, 1'b0);
    run_op("rr second", 2'b11, 2, 1'b1, 4'b1001, 1'b0, 1'b0);
    run_op("rr third", 2'b11, 2, 1'b0, 4'b0111, 1'b1, 1'b0);

    a0_i = 4'b0101; b0_i = 4'b0011;
    run_op("or scramble", 2'b01, 2, 1'b0, 4'b0111, 1'b1, 1'b1);

    op0_i = 2'b10; a0_i = 4'b1111; b0_i = 4'b1111;
    req_i = 2'b01;
    tick();
    req_i = 2'b00;
    tick();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid reset");
    check_eq("mid reset id", id_o, 1'b0);
    check_eq("mid reset result", result_o, 4'b0000);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_idle_outputs("post reset");
    end

    op0_i = 2'b01; a0_i = 4'b0101; b0_i = 4'b0011;
    op1_i = 2'b00; a1_i = 4'b0000;
    run_op("tie after reset", 2'b11, 2, 1'b0, 4'b0111, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nor_op_scheduler.md
NOR_OP_SCHEDULER -- requirements
Module: nor_op_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand/result bit width (all ops bitwise).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_i  input  2  per-requester request level, bit n = requester n.
REQ-005 SHALL have port op0_i / op1_i  input  2 each  opcode per requester: 00 NOT a, 01 OR, 10 AND, 11 IMPLY (~a|b).
REQ-006 SHALL have port a0_i, b0_i, a1_i, b1_i  input  WIDTH each  operands per requester.
REQ-007 SHALL have port gnt_o  output  2  one-hot grant pulse.
REQ-008 SHALL have port busy_o  output  1  high from first step cycle through DONE cycle.
REQ-009 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port id_o  output  1  requester served, valid with done_o.
REQ-011 SHALL have port result_o  output  WIDTH  result, valid with done_o, held until next done_o.

Function
REQ-012 SHALL evaluate every op using exactly one shared WIDTH-bit NOR cell, one NOR per step cycle, with muxed inputs.
REQ-013 SHALL use FSM states IDLE, S1, S2, S3, DONE.
REQ-014 In IDLE with req_i != 0, the clock edge SHALL latch winner id, op, a, b and move to S1; with req_i == 0, stay in IDLE.
REQ-015 Round-robin arbitration: single requester wins; if both request, the requester not served last wins; after reset requester 0 wins ties.
REQ-016 gnt_o[winner] SHALL be 1 for exactly the S1 cycle; 0 otherwise.
REQ-017 Step schedule (t1, t2 internal WIDTH-bit temps; r = result):
- NOT: S1 r=nor(a,a).
- OR: S1 t1=nor(a,b); S2 r=nor(t1,t1).
- AND: S1 t1=nor(a,a); S2 t2=nor(b,b); S3 r=nor(t1,t2).
- IMPLY: S1 t1=nor(a,a); S2 t2=nor(t1,b); S3 r=nor(t2,t2).
REQ-018 After the op's last step the FSM SHALL enter DONE, skipping unused steps (NOT S1→DONE, OR S2→DONE).
REQ-019 Latency: done_o visible N+1 cycles after the IDLE sampling edge (N = 1/2/3/3 for NOT/OR/AND/IMPLY).
REQ-020 DONE SHALL return to IDLE unconditionally; back-to-back service gives one IDLE cycle between operations.
REQ-021 Requests are levels; req_i changes or operand changes after the latching edge SHALL NOT affect the op in flight.
REQ-022 A requester still asserting req_i in the next IDLE SHALL be served again, subject to REQ-015.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, gnt_o=0, busy_o=0, done_o=0, id_o=0, result_o=0, temps=0, and the round-robin pointer to favour requester 0.
REQ-024 Reset during S1..DONE SHALL discard the op; no done_o for it after release.

Structure
REQ-025 Opcode encodings and FSM state encodings SHALL reside in a shared package, nor_op_pkg.
REQ-026 The shared NOR SHALL be a separate sub-module nor_cell (WIDTH-parameterised, combinational, output ~(x|y)).

Verification
REQ-027 Reset: rst_n=0 → all outputs 0; after release with req_i=0 for 5 cycles → busy_o=0, done_o=0.
REQ-028 req_i=01, op0=AND, a0=1100, b0=1010 → gnt_o=01 one cycle after the sampling edge; done_o 4 cycles after it; id_o=0, result_o=1000.
REQ-029 req_i=10, op1=IMPLY, a1=1100, b1=1010 → done_o after 4 cycles, id_o=1, result_o=1011; op1=NOT, a1=0110 → done_o after 2 cycles, result_o=1001.
REQ-030 req_i=11 held, op0=OR a0=0101 b0=0011, op1=OR a1=1000 b1=0001 → first done id_o=0 result_o=0111, next done id_o=1 result_o=1001, then id_o=0 again (alternation).
REQ-031 Start AND, pull rst_n low during S2 → outputs 0 immediately; after release no done_o until a new request is sampled.
REQ-032 Change a0_i/b0_i every cycle during an in-flight OR with latched a0=0101, b0=0011 → result_o still 0111.
